// File: rtl/acondicionador_entradas.sv
// acondicionador_entradas: synchronizes, debounces and edge-detects the board
// buttons and switches feeding the RTC control top. Buttons arriba/abajo also
// auto-repeat while held alone.
module acondicionador_entradas #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 15000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] push_raw,
  input  logic [3:0] sw_raw,
  output logic [3:0] push_pulse,
  output logic [3:0] sw_level,
  output logic [3:0] push_level
);

  localparam int unsigned NUM_IN  = 8;
  localparam int unsigned NUM_REP = 2;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Buttons occupy bits 3:0, switches bits 7:4 of the combined vectors.
  logic [NUM_IN-1:0] raw_all;
  logic [NUM_IN-1:0] sync_meta;
  logic [NUM_IN-1:0] sync;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] stable_next;
  logic [DB_W-1:0]   db_cnt [NUM_IN];

  logic [3:0] push_next;
  logic [3:0] push_rise;
  logic [3:0] edge_pulse;
  logic [3:0] others;

  rep_state_t         rep_state [NUM_REP];
  logic [REP_W-1:0]   rep_cnt   [NUM_REP];
  logic [NUM_REP-1:0] rep_abort;
  logic [NUM_REP-1:0] rep_fire;
  logic [3:0]         rise_others;

  assign raw_all    = {sw_raw, push_raw};
  assign push_level = stable[3:0];
  assign sw_level   = stable[7:4];

  // Two-flop synchronizer for every raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= raw_all;
      sync      <= sync_meta;
    end
  end

  // Stable value each input will hold after this edge; lets pulses line up with the level.
  always_comb begin
    stable_next = stable;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if ((sync[i] != stable[i]) && (db_cnt[i] == DB_LAST)) begin
        stable_next[i] = sync[i];
      end
    end
  end

  // Per-input debounce counters and stable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      stable <= stable_next;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if ((sync[i] == stable[i]) || (db_cnt[i] == DB_LAST)) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign push_next = stable_next[3:0];
  assign push_rise = push_next & ~stable[3:0];

  // A press counts only if it qualifies while no other button is stable-high.
  always_comb begin
    edge_pulse = '0;
    others     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      others        = push_next;
      others[i]     = 1'b0;
      edge_pulse[i] = push_rise[i] && (others == 4'b0000);
    end
  end

  // Repeat abort/fire decisions: release or another press cancels silently.
  always_comb begin
    rep_abort   = '0;
    rep_fire    = '0;
    rise_others = '0;
    for (int unsigned i = 0; i < NUM_REP; i++) begin
      rise_others    = push_rise;
      rise_others[i] = 1'b0;
      rep_abort[i]   = !push_next[i] || (rise_others != 4'b0000);
      rep_fire[i]    = !rep_abort[i] &&
                       (((rep_state[i] == ST_DELAY)  && (rep_cnt[i] == DELAY_LAST)) ||
                        ((rep_state[i] == ST_REPEAT) && (rep_cnt[i] == PERIOD_LAST)));
    end
  end

  // Auto-repeat FSMs for arriba (bit 0) and abajo (bit 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REP; i++) begin
        rep_state[i] <= ST_IDLE;
        rep_cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REP; i++) begin
        case (rep_state[i])
          ST_IDLE: begin
            rep_cnt[i] <= '0;
            if (edge_pulse[i]) begin
              rep_state[i] <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (rep_abort[i]) begin
              rep_state[i] <= ST_IDLE;
              rep_cnt[i]   <= '0;
            end else if (rep_cnt[i] == DELAY_LAST) begin
              rep_state[i] <= ST_REPEAT;
              rep_cnt[i]   <= '0;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rep_abort[i]) begin
              rep_state[i] <= ST_IDLE;
              rep_cnt[i]   <= '0;
            end else if (rep_cnt[i] == PERIOD_LAST) begin
              rep_cnt[i] <= '0;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
            end
          end
          default: begin
            rep_state[i] <= ST_IDLE;
            rep_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Registered action pulses: press edges plus repeat pulses of bits 0/1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_pulse <= '0;
    end else begin
      push_pulse <= edge_pulse | {2'b00, rep_fire};
    end
  end

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Bench for acondicionador_entradas: the driver queues every expected change of
// {push_pulse, push_level, sw_level} with its cycle; the monitor pops one entry
// per observed change and compares.
module tb_acondicionador_entradas;

  localparam int LAT = 6;

  logic       clk;
  logic       reset;
  logic [3:0] push_raw;
  logic [3:0] sw_raw;
  logic [3:0] push_pulse;
  logic [3:0] sw_level;
  logic [3:0] push_level;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
    logic [3:0] plev;
    logic [3:0] slev;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  acondicionador_entradas #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push_raw(push_raw),
    .sw_raw(sw_raw),
    .push_pulse(push_pulse),
    .sw_level(sw_level),
    .push_level(push_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] pl,
                           input logic [3:0] sl);
    ev_t e;
    e.cyc   = c;
    e.pulse = p;
    e.plev  = pl;
    e.slev  = sl;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ((push_pulse !== 4'b0) || (push_level !== 4'b0) || (sw_level !== 4'b0)) begin
      errors++;
      $display("FAIL %s: pulse=%b plev=%b slev=%b, expected all 0", name,
               push_pulse, push_level, sw_level);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge; every change is an event.
  initial begin : monitor
    logic [3:0] prev_p;
    logic [3:0] prev_pl;
    logic [3:0] prev_sl;
    ev_t        e;
    prev_p  = 4'b0;
    prev_pl = 4'b0;
    prev_sl = 4'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if ((push_pulse !== prev_p) || (push_level !== prev_pl) || (sw_level !== prev_sl)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cycle=%0d pulse=%b plev=%b slev=%b, expected no change",
                   cyc, push_pulse, push_level, sw_level);
        end else begin
          e = exp_q.pop_front();
          if ((e.cyc != cyc) || (push_pulse !== e.pulse) || (push_level !== e.plev) ||
              (sw_level !== e.slev)) begin
            errors++;
            $display("FAIL event: got cycle=%0d pulse=%b plev=%b slev=%b, expected cycle=%0d pulse=%b plev=%b slev=%b",
                     cyc, push_pulse, push_level, sw_level, e.cyc, e.pulse, e.plev, e.slev);
          end
        end
        prev_p  = push_pulse;
        prev_pl = push_level;
        prev_sl = sw_level;
      end
    end
  end

  initial begin : driver
    int n;
    int t;
    int m;
    reset    = 1'b1;
    push_raw = 4'b0;
    sw_raw   = 4'b0;
    tick(3);
    reset = 1'b0;
    tick(4);

    // All inputs high together: levels qualify, no button pulses.
    n = cyc;
    push_raw = 4'hF;
    sw_raw   = 4'hF;
    expect_ev(n + LAT, 4'b0, 4'hF, 4'hF);
    tick(10);

    // Asynchronous reset with inputs high, then requalification.
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    expect_ev(cyc + 1, 4'b0, 4'b0, 4'b0);
    tick(2);
    reset = 1'b0;
    m = cyc;
    expect_ev(m + LAT, 4'b0, 4'hF, 4'hF);
    tick(10);
    n = cyc;
    push_raw = 4'b0;
    sw_raw   = 4'b0;
    expect_ev(n + LAT, 4'b0, 4'b0, 4'b0);
    tick(10);

    // Glitch on izquierda shorter than the debounce window.
    push_raw[2] = 1'b1;
    tick(3);
    push_raw[2] = 1'b0;
    tick(10);

    // Real izquierda press: one pulse, no repeat.
    n = cyc;
    push_raw[2] = 1'b1;
    expect_ev(n + LAT,     4'b0100, 4'b0100, 4'b0);
    expect_ev(n + LAT + 1, 4'b0000, 4'b0100, 4'b0);
    tick(30);
    n = cyc;
    push_raw[2] = 1'b0;
    expect_ev(n + LAT, 4'b0, 4'b0, 4'b0);
    tick(10);

    // Arriba held 60 cycles: first pulse then repeats at +20, +28 ... +52.
    n = cyc;
    t = n + LAT;
    push_raw[0] = 1'b1;
    expect_ev(t,     4'b0001, 4'b0001, 4'b0);
    expect_ev(t + 1, 4'b0000, 4'b0001, 4'b0);
    for (int k = 20; k <= 52; k += 8) begin
      expect_ev(t + k,     4'b0001, 4'b0001, 4'b0);
      expect_ev(t + k + 1, 4'b0000, 4'b0001, 4'b0);
    end
    tick(60);
    push_raw[0] = 1'b0;
    expect_ev(t + 60, 4'b0, 4'b0, 4'b0);
    tick(12);

    // Abajo held, derecha pressed at T+10: repeat aborted, derecha never pulses.
    n = cyc;
    t = n + LAT;
    push_raw[1] = 1'b1;
    expect_ev(t,     4'b0010, 4'b0010, 4'b0);
    expect_ev(t + 1, 4'b0000, 4'b0010, 4'b0);
    tick(16);
    push_raw[3] = 1'b1;
    expect_ev(t + 16, 4'b0000, 4'b1010, 4'b0);
    tick(30);
    n = cyc;
    push_raw[3] = 1'b0;
    expect_ev(n + LAT, 4'b0000, 4'b0010, 4'b0);
    tick(40);
    n = cyc;
    push_raw[1] = 1'b0;
    expect_ev(n + LAT, 4'b0, 4'b0, 4'b0);
    tick(10);

    // Bouncing crono switch settles once.
    for (int k = 0; k < 3; k++) begin
      sw_raw[1] = 1'b1;
      tick(1);
      sw_raw[1] = 1'b0;
      tick(2);
    end
    n = cyc;
    sw_raw[1] = 1'b1;
    expect_ev(n + LAT, 4'b0, 4'b0, 4'b0010);
    tick(10);
    n = cyc;
    sw_raw[1] = 1'b0;
    expect_ev(n + LAT, 4'b0, 4'b0, 4'b0);
    tick(10);

    // Reset during arriba repeat, button still held afterwards.
    n = cyc;
    t = n + LAT;
    push_raw[0] = 1'b1;
    expect_ev(t,      4'b0001, 4'b0001, 4'b0);
    expect_ev(t + 1,  4'b0000, 4'b0001, 4'b0);
    expect_ev(t + 20, 4'b0001, 4'b0001, 4'b0);
    expect_ev(t + 21, 4'b0000, 4'b0001, 4'b0);
    tick(28);
    reset = 1'b1;
    #1;
    check_zero("reset_mid_repeat");
    expect_ev(cyc + 1, 4'b0, 4'b0, 4'b0);
    tick(1);
    reset = 1'b0;
    m = cyc;
    expect_ev(m + 6,  4'b0001, 4'b0001, 4'b0);
    expect_ev(m + 7,  4'b0000, 4'b0001, 4'b0);
    expect_ev(m + 26, 4'b0001, 4'b0001, 4'b0);
    expect_ev(m + 27, 4'b0000, 4'b0001, 4'b0);
    tick(28);
    push_raw[0] = 1'b0;
    expect_ev(m + 34, 4'b0, 4'b0, 4'b0);
    tick(15);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got none, expected cycle=%0d pulse=%b plev=%b slev=%b",
               e.cyc, e.pulse, e.plev, e.slev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
